// File: rtl/fb_pkg.sv
// fb_pkg: frame buffer geometry, fetch states and pixel types shared by the line fetcher
package fb_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL = 525;
  localparam int WORDS_PER_LINE = H_ACTIVE / 2;
  localparam int LA_W = $clog2(WORDS_PER_LINE);
  localparam logic [19:0] FRAME0_BASE = 20'h00000;
  localparam logic [19:0] FRAME1_BASE = 20'h25800;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_e;
  typedef logic [4:0] pixel_idx_t;
  // t*320 as shift-add so no multiplier is inferred
  function automatic logic [19:0] line_offset(input logic [9:0] t);
    return ({10'b0, t} << 8) + ({10'b0, t} << 6);
  endfunction
endpackage

// File: rtl/line_buffer_pp.sv
// line_buffer_pp: two-bank scanline RAM with one write port and a registered read port
module line_buffer_pp
  import fb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic            wbank,
  input  logic [LA_W-1:0] waddr,
  input  logic [9:0]      wdata,
  input  logic            rbank,
  input  logic [LA_W-1:0] raddr,
  output logic [9:0]      rdata
);
  logic [9:0] mem [2][WORDS_PER_LINE];
  logic [9:0] rd_q;
  always_ff @(posedge clk) begin
    if (we) mem[wbank][waddr] <= wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else rd_q <= mem[rbank][raddr];
  end
  assign rdata = rd_q;
endmodule

// File: rtl/frame_line_fetcher.sv
// frame_line_fetcher: prefetches the next scanline from the front SRAM frame and streams palette indices
module frame_line_fetcher
  import fb_pkg::*;
(
  input  logic        frame_Clk,
  input  logic        Reset_n,
  input  logic        VS,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        swap_req,
  output logic        sram_req,
  output logic [19:0] sram_addr,
  input  logic        sram_gnt,
  input  logic        sram_rvalid,
  input  logic [15:0] sram_rdata,
  output pixel_idx_t  pixelOut,
  output logic        front_sel,
  output logic        swap_ack,
  output logic        underrun
);
  localparam logic [LA_W-1:0] LAST = LA_W'(WORDS_PER_LINE - 1);
  fetch_state_e state_q, state_d;
  logic [9:0] drawy_q, t, rd_word;
  logic primed_q, vs_q, new_line, start, wr, vis, vis_q, odd_q, swap;
  logic [LA_W-1:0] req_cnt_q, req_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic wbank_q, wbank_d, sram_req_q, sram_req_d, front_sel_q, front_sel_d;
  logic swap_pending_q, swap_pending_d, swap_ack_q, swap_ack_d, underrun_q, underrun_d;
  logic [19:0] sram_addr_q, sram_addr_d;
  logic unused_rdata;
  assign unused_rdata = ^sram_rdata[15:10];
  always_comb begin
    new_line = primed_q && (DrawY != drawy_q);
    t = (DrawY == 10'(V_TOTAL - 1)) ? '0 : DrawY + 10'd1;
    start = new_line && (state_q == IDLE) && (t < 10'(V_ACTIVE));
    wr = sram_rvalid && (state_q != IDLE);
    vis = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
    swap = vs_q && !VS && (swap_pending_q || swap_req);
    state_d = state_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = wr ? rsp_cnt_q + LA_W'(1) : rsp_cnt_q;
    wbank_d = wbank_q;
    sram_req_d = sram_req_q;
    sram_addr_d = sram_addr_q;
    front_sel_d = front_sel_q ^ swap;
    swap_pending_d = (swap_pending_q || swap_req) && !swap;
    swap_ack_d = swap;
    underrun_d = underrun_q || (new_line && state_q != IDLE);
    if (start) begin
      state_d = REQ;
      req_cnt_d = '0;
      rsp_cnt_d = '0;
      wbank_d = t[0];
      sram_req_d = 1'b1;
      sram_addr_d = (front_sel_q ? FRAME1_BASE : FRAME0_BASE) + line_offset(t);
    end
    if (state_q == REQ && sram_gnt) begin
      req_cnt_d = req_cnt_q + LA_W'(1);
      sram_addr_d = sram_addr_q + 20'd1;
      if (req_cnt_q == LAST) begin
        sram_req_d = 1'b0;
        state_d = DRAIN;
      end
    end
    if (state_q == DRAIN && wr && rsp_cnt_q == LAST) state_d = IDLE;
  end
  always_ff @(posedge frame_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      drawy_q <= '0;
      primed_q <= 1'b0;
      vs_q <= 1'b0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      wbank_q <= 1'b0;
      sram_req_q <= 1'b0;
      sram_addr_q <= '0;
      front_sel_q <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_ack_q <= 1'b0;
      underrun_q <= 1'b0;
      vis_q <= 1'b0;
      odd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drawy_q <= DrawY;
      primed_q <= 1'b1;
      vs_q <= VS;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      wbank_q <= wbank_d;
      sram_req_q <= sram_req_d;
      sram_addr_q <= sram_addr_d;
      front_sel_q <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      swap_ack_q <= swap_ack_d;
      underrun_q <= underrun_d;
      vis_q <= vis;
      odd_q <= DrawX[0];
    end
  end
  // line y reads bank y[0] while line y+1 fills the other bank
  line_buffer_pp u_lb (
    .clk(frame_Clk),
    .rst_n(Reset_n),
    .we(wr),
    .wbank(wbank_q),
    .waddr(rsp_cnt_q),
    .wdata(sram_rdata[9:0]),
    .rbank(DrawY[0]),
    .raddr(vis ? DrawX[9:1] : '0),
    .rdata(rd_word)
  );
  assign pixelOut = vis_q ? (odd_q ? rd_word[9:5] : rd_word[4:0]) : '0;
  assign sram_req = sram_req_q;
  assign sram_addr = sram_addr_q;
  assign front_sel = front_sel_q;
  assign swap_ack = swap_ack_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_frame_line_fetcher.sv
// tb_frame_line_fetcher: scoreboard bench with a behavioural SRAM arbiter and pixel/address monitors
module tb_frame_line_fetcher;
  logic frame_Clk = 1'b0, Reset_n = 1'b0, VS = 1'b1, swap_req = 1'b0;
  logic sram_gnt = 1'b0, sram_rvalid = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic [15:0] sram_rdata = '0;
  logic sram_req, front_sel, swap_ack, underrun;
  logic [19:0] sram_addr;
  logic [4:0] pixelOut;
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit stall = 0, withhold = 0;
  typedef struct {int due; logic [19:0] a;} rsp_t;
  typedef struct {int due; logic [4:0] v;} pix_t;
  rsp_t rsp_q[$];
  pix_t pix_q[$];
  pix_t mon_p;
  logic [19:0] addr_q[$];
  int xs[12] = '{0, 1, 2, 3, 64, 65, 318, 319, 638, 639, 640, 700};

  frame_line_fetcher dut (
    .frame_Clk(frame_Clk), .Reset_n(Reset_n), .VS(VS), .DrawX(DrawX), .DrawY(DrawY),
    .swap_req(swap_req), .sram_req(sram_req), .sram_addr(sram_addr), .sram_gnt(sram_gnt),
    .sram_rvalid(sram_rvalid), .sram_rdata(sram_rdata), .pixelOut(pixelOut),
    .front_sel(front_sel), .swap_ack(swap_ack), .underrun(underrun)
  );

  always #5 frame_Clk = ~frame_Clk;
  always @(posedge frame_Clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [19:0] a);
    if (a == 20'd1920) return 16'h0143;
    return {6'h2A, a[4:0] ^ a[12:8], a[9:5] + 5'd3};
  endfunction

  function automatic logic [4:0] pix(int f, int y, int x);
    logic [15:0] w;
    if (x >= 640 || y >= 480) return 5'd0;
    w = mem_word(20'((f != 0 ? 'h25800 : 0) + y * 320 + x / 2));
    return (x % 2 == 1) ? w[9:5] : w[4:0];
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_fetch(int t, int f);
    for (int i = 0; i < 320; i++) addr_q.push_back(20'((f != 0 ? 'h25800 : 0) + t * 320 + i));
  endtask

  task automatic wait_done(string name, int budget, bit incl_rsp);
    int n = 0;
    while ((addr_q.size() > 0 || (incl_rsp && rsp_q.size() > 0)) && n < budget) begin
      @(negedge frame_Clk);
      n++;
    end
    chk({name, "_pending"}, addr_q.size() + (incl_rsp ? rsp_q.size() : 0), 0);
    repeat (3) @(negedge frame_Clk);
  endtask

  task automatic sweep(int y, int f);
    foreach (xs[i]) begin
      @(negedge frame_Clk);
      DrawX = 10'(xs[i]);
      pix_q.push_back('{cyc + 1, pix(f, y, xs[i])});
    end
    repeat (2) @(negedge frame_Clk);
  endtask

  // behavioural arbiter: grants, returns data two cycles after each accepted request
  always @(negedge frame_Clk) begin
    sram_gnt = stall ? (cyc % 4 == 0) : 1'b1;
    if (Reset_n && sram_req && sram_gnt) rsp_q.push_back('{cyc + 2, sram_addr});
    sram_rvalid = 1'b0;
    if (!withhold && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      sram_rvalid = 1'b1;
      sram_rdata = mem_word(rsp_q[0].a);
      void'(rsp_q.pop_front());
    end
  end

  always @(negedge frame_Clk) begin
    #2;
    if (Reset_n && sram_req) begin
      if (addr_q.size() == 0) chk("req_without_expectation", int'(sram_req), 0);
      else if (sram_gnt) chk("granted_addr", int'(sram_addr), int'(addr_q.pop_front()));
      else chk("held_addr", int'(sram_addr), int'(addr_q[0]));
    end
    while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
      mon_p = pix_q.pop_front();
      chk("pixelOut", int'(pixelOut), int'(mon_p.v));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge frame_Clk);
    chk("rst_pixelOut", pixelOut, 0);
    chk("rst_front_sel", front_sel, 0);
    chk("rst_swap_ack", swap_ack, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_sram_req", sram_req, 0);
    chk("rst_sram_addr", int'(sram_addr), 0);
    Reset_n = 1'b1;
    repeat (5) @(negedge frame_Clk);
    chk("idle_sram_req", sram_req, 0);
    @(negedge frame_Clk);
    DrawY = 10'd4;
    push_fetch(5, 0);
    repeat (20) @(negedge frame_Clk);
    #3 Reset_n = 1'b0;
    #1;
    chk("async_rst_req", sram_req, 0);
    chk("async_rst_addr", int'(sram_addr), 0);
    chk("async_rst_pixel", pixelOut, 0);
    addr_q.delete();
    repeat (3) @(negedge frame_Clk);
    Reset_n = 1'b1;
    repeat (12) @(negedge frame_Clk);
    chk("post_rst_no_req", sram_req, 0);
    @(negedge frame_Clk);
    DrawY = 10'd5;
    push_fetch(6, 0);
    wait_done("fetch6", 1000, 1);
    @(negedge frame_Clk);
    DrawY = 10'd6;
    push_fetch(7, 0);
    sweep(6, 0);
    wait_done("fetch7", 1000, 1);
    stall = 1;
    @(negedge frame_Clk);
    DrawY = 10'd8;
    push_fetch(9, 0);
    wait_done("stall9", 3000, 1);
    stall = 0;
    @(negedge frame_Clk);
    DrawY = 10'd9;
    push_fetch(10, 0);
    sweep(9, 0);
    wait_done("fetch10", 1000, 1);
    chk("underrun_clear", underrun, 0);
    @(negedge frame_Clk);
    DrawY = 10'd479;
    repeat (6) @(negedge frame_Clk);
    DrawY = 10'd480;
    repeat (6) @(negedge frame_Clk);
    DrawY = 10'd500;
    sweep(500, 0);
    @(negedge frame_Clk);
    DrawY = 10'd100;
    push_fetch(101, 0);
    wait_done("fetch101", 1000, 1);
    @(negedge frame_Clk) swap_req = 1'b1;
    @(negedge frame_Clk) swap_req = 1'b0;
    @(negedge frame_Clk) swap_req = 1'b1;
    @(negedge frame_Clk) swap_req = 1'b0;
    @(negedge frame_Clk);
    chk("pending_front_sel", front_sel, 0);
    chk("pending_swap_ack", swap_ack, 0);
    DrawY = 10'd490;
    repeat (3) @(negedge frame_Clk);
    VS = 1'b0;
    @(negedge frame_Clk);
    chk("swap_ack_pulse", swap_ack, 1);
    chk("swap_front_sel", front_sel, 1);
    @(negedge frame_Clk);
    chk("swap_ack_one_cycle", swap_ack, 0);
    chk("swap_front_hold", front_sel, 1);
    VS = 1'b1;
    @(negedge frame_Clk);
    DrawY = 10'd524;
    push_fetch(0, 1);
    wait_done("fetch0_f1", 1000, 1);
    @(negedge frame_Clk);
    DrawY = 10'd0;
    push_fetch(1, 1);
    sweep(0, 1);
    wait_done("fetch1_f1", 1000, 1);
    @(negedge frame_Clk);
    swap_req = 1'b1;
    VS = 1'b0;
    @(negedge frame_Clk);
    swap_req = 1'b0;
    chk("coincident_ack", swap_ack, 1);
    chk("coincident_front", front_sel, 0);
    @(negedge frame_Clk);
    chk("coincident_ack_off", swap_ack, 0);
    VS = 1'b1;
    @(negedge frame_Clk);
    VS = 1'b0;
    @(negedge frame_Clk);
    @(negedge frame_Clk);
    chk("no_pending_ack", swap_ack, 0);
    chk("no_pending_front", front_sel, 0);
    VS = 1'b1;
    withhold = 1;
    @(negedge frame_Clk);
    DrawY = 10'd10;
    push_fetch(11, 0);
    wait_done("reqs11", 1000, 0);
    DrawY = 10'd11;
    @(negedge frame_Clk);
    @(negedge frame_Clk);
    chk("underrun_set", underrun, 1);
    withhold = 0;
    wait_done("drain11", 1000, 1);
    repeat (10) @(negedge frame_Clk);
    chk("underrun_no_extra_req", sram_req, 0);
    DrawY = 10'd12;
    push_fetch(13, 0);
    wait_done("fetch13", 1000, 1);
    chk("underrun_sticky", underrun, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
